// File: rtl/cgra_offload_ctrl.sv
// Stalls the RISC-V pipeline while a custom-0 instruction in EX runs on the CGRA,
// then releases it for one cycle with the CGRA result steered onto VALUResult.
module cgra_offload_ctrl #(
    parameter logic [6:0] OPCODE  = 7'b0001011,
    parameter int         TIMEOUT = 1024,
    parameter int         CNT_W   = 11
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic [31:0] ex_instr_i,
    input  logic        ex_valid_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        cgra_req_o,
    output logic [9:0]  cgra_func_o,
    output logic [31:0] cgra_opa_o,
    output logic [31:0] cgra_opb_o,
    input  logic        cgra_ack_i,
    input  logic        cgra_done_i,
    input  logic [31:0] cgra_result_i,
    output logic        stall_o,
    output logic        valu_sel_o,
    output logic [31:0] valu_result_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             skip_q;
    logic             hit;
    logic [CNT_W-1:0] cnt_q;
    logic             unused_instr;

    assign unused_instr = ^{ex_instr_i[24:15], ex_instr_i[11:7]};

    // start_i gates hit so the combinational stall path is also quiet during reset.
    assign hit = start_i & ex_valid_i & (ex_instr_i[6:0] == OPCODE) & ~skip_q;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        valu_sel_o = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = hit;
                if (hit) state_d = ISSUE;
            end
            ISSUE: begin
                stall_o = 1'b1;
                if (cgra_ack_i) state_d = cgra_done_i ? WB : WAIT;
            end
            WAIT: begin
                stall_o = 1'b1;
                if (cgra_done_i || cnt_q == CNT_LAST) state_d = WB;
            end
            WB: begin
                valu_sel_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            skip_q        <= 1'b0;
            cgra_req_o    <= 1'b0;
            cgra_func_o   <= '0;
            cgra_opa_o    <= '0;
            cgra_opb_o    <= '0;
            cnt_q         <= '0;
            valu_result_o <= '0;
            timeout_o     <= 1'b0;
        end else begin
            // Masks the just-retired offload, which is still visible in EX for one cycle.
            skip_q <= (state_q == WB);
            case (state_q)
                IDLE: if (hit) begin
                    cgra_opa_o  <= rs1_data_i;
                    cgra_opb_o  <= rs2_data_i;
                    cgra_func_o <= {ex_instr_i[31:25], ex_instr_i[14:12]};
                    cgra_req_o  <= 1'b1;
                end
                ISSUE: if (cgra_ack_i) begin
                    cgra_req_o <= 1'b0;
                    cnt_q      <= '0;
                    if (cgra_done_i) valu_result_o <= cgra_result_i;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cgra_done_i) begin
                        valu_result_o <= cgra_result_i;
                    end else if (cnt_q == CNT_LAST) begin
                        valu_result_o <= '0;
                        timeout_o     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
